// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: walks T0..T(STEPS-1), decodes opcode and ALU
// flags into the 16-bit control word, and freezes the machine after HLT.
module control_sequencer #(
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic [1:0]  flags,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
  localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
  localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
  localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

  localparam logic [2:0] LAST = 3'(STEPS - 1);

  logic [15:0] word;

  always_comb begin
    word = '0;
    case (step)
      3'd0: word = MI | CO;
      3'd1: word = RO | II | CE;
      3'd2: begin
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4: word = IO | MI;
          4'h5: word = IO | AI;
          4'h6: word = IO | J;
          4'h7: word = flags[0] ? (IO | J) : 16'h0000;
          4'h8: word = flags[1] ? (IO | J) : 16'h0000;
          4'hE: word = AO | OI;
          4'hF: word = HLT;
          default: word = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          4'h1: word = RO | AI;
          4'h2, 4'h3: word = RO | BI;
          4'h4: word = AO | RI;
          default: word = '0;
        endcase
      end
      3'd4: begin
        case (opcode)
          4'h2: word = EO | AI | FI;
          4'h3: word = EO | AI | SU | FI;
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

  // Reset and halt both blank the word so the datapath sees no enables.
  assign ctrl = (reset || halted) ? 16'h0000 : word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step   <= 3'd0;
      halted <= 1'b0;
    end else if (run && !halted) begin
      if (word[15]) begin
        halted <= 1'b1;
      end else if (step == LAST || (EARLY_END && step >= 3'd2 && word == 16'h0000)) begin
        step <= 3'd0;
      end else begin
        step <= step + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance without and one with early end,
// driven from the same inputs and reset before each scenario.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic [1:0]  flags = 2'b00;
  logic [15:0] ctrl0, ctrl1;
  logic [2:0]  step0, step1;
  logic        halted0, halted1;

  int vectors = 0;
  int errors  = 0;

  control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .flags(flags),
    .ctrl(ctrl0), .step(step0), .halted(halted0)
  );

  control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .flags(flags),
    .ctrl(ctrl1), .step(step1), .halted(halted1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic chk1(input string name, input logic [15:0] c, input logic [2:0] s);
    vectors++;
    if (ctrl1 !== c || step1 !== s) begin
      errors++;
      $display("FAIL %s: got ctrl=%h step=%0d, expected ctrl=%h step=%0d", name, ctrl1, step1, c, s);
    end
  endtask

  task automatic test_reset();
    run = 1'b1; opcode = 4'h2; flags = 2'b00;
    reset = 1'b1;
    #2;
    vectors++;
    if (step1 !== 3'd0 || halted1 !== 1'b0 || ctrl1 !== 16'h0000 || ctrl0 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: got step=%0d halted=%b ctrl1=%h ctrl0=%h, expected 0 0 0000 0000",
               step1, halted1, ctrl1, ctrl0);
    end
    reset = 1'b0;
    #1;
    chk1("reset_release", 16'h4004, 3'd0);
  endtask

  task automatic test_lda_full();
    logic [15:0] exp_c [5] = '{16'h4004, 16'h1408, 16'h4800, 16'h1200, 16'h0000};
    opcode = 4'h1; run = 1'b1;
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (ctrl0 !== exp_c[i] || step0 !== 3'(i)) begin
        errors++;
        $display("FAIL lda_T%0d: got ctrl=%h step=%0d, expected ctrl=%h step=%0d",
                 i, ctrl0, step0, exp_c[i], i);
      end
      tick();
    end
    vectors++;
    if (step0 !== 3'd0 || ctrl0 !== 16'h4004) begin
      errors++;
      $display("FAIL lda_wrap: got ctrl=%h step=%0d, expected ctrl=4004 step=0", ctrl0, step0);
    end
  endtask

  task automatic test_alu();
    opcode = 4'h3;
    pulse_reset();
    repeat (4) tick();
    chk1("sub_T4", 16'h02C1, 3'd4);
    tick();
    chk1("sub_wrap", 16'h4004, 3'd0);
    opcode = 4'h2;
    pulse_reset();
    repeat (4) tick();
    chk1("add_T4", 16'h0281, 3'd4);
  endtask

  task automatic test_jumps();
    opcode = 4'h7; flags = 2'b01;
    pulse_reset();
    repeat (2) tick();
    chk1("jc_taken_T2", 16'h0802, 3'd2);
    tick();
    chk1("jc_taken_T3", 16'h0000, 3'd3);
    tick();
    chk1("jc_taken_end", 16'h4004, 3'd0);
    flags = 2'b00;
    pulse_reset();
    repeat (2) tick();
    chk1("jc_not_T2", 16'h0000, 3'd2);
    tick();
    chk1("jc_not_early", 16'h4004, 3'd0);
    opcode = 4'h8; flags = 2'b10;
    pulse_reset();
    repeat (2) tick();
    chk1("jz_taken_T2", 16'h0802, 3'd2);
    flags = 2'b01;
    #1;
    chk1("jz_not_T2", 16'h0000, 3'd2);
    opcode = 4'hA;
    #1;
    chk1("nop_a_T2", 16'h0000, 3'd2);
    flags = 2'b00;
  endtask

  task automatic test_halt();
    opcode = 4'hF;
    pulse_reset();
    repeat (2) tick();
    chk1("hlt_T2", 16'h8000, 3'd2);
    tick();
    vectors++;
    if (halted1 !== 1'b1 || ctrl1 !== 16'h0000 || step1 !== 3'd2) begin
      errors++;
      $display("FAIL hlt_enter: got halted=%b ctrl=%h step=%0d, expected 1 0000 2", halted1, ctrl1, step1);
    end
    repeat (10) tick();
    vectors++;
    if (halted1 !== 1'b1 || ctrl1 !== 16'h0000 || step1 !== 3'd2 ||
        halted0 !== 1'b1 || step0 !== 3'd2) begin
      errors++;
      $display("FAIL hlt_hold: got halted=%b/%b ctrl=%h step=%0d/%0d, expected 1/1 0000 2/2",
               halted1, halted0, ctrl1, step1, step0);
    end
    reset = 1'b1;
    #2;
    vectors++;
    if (halted1 !== 1'b0 || step1 !== 3'd0) begin
      errors++;
      $display("FAIL hlt_reset: got halted=%b step=%0d, expected 0 0", halted1, step1);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_pause();
    opcode = 4'h2; run = 1'b1;
    pulse_reset();
    repeat (3) tick();
    chk1("add_T3", 16'h1020, 3'd3);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("pause_hold", 16'h1020, 3'd3);
    end
    run = 1'b1;
    tick();
    chk1("pause_resume", 16'h0281, 3'd4);
  endtask

  // Instructions issued back to back with early end; expected words are hand-decoded.
  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{4'hE, 4'h5, 4'h4, 4'h6};
    logic [15:0] t2  [4] = '{16'h0110, 16'h0A00, 16'h4800, 16'h0802};
    logic [15:0] t3  [4] = '{16'h0000, 16'h0000, 16'h2100, 16'h0000};
    logic [15:0] e;
    logic [2:0]  s;
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      #1;
      s = 3'd0;
      for (int n = 0; n < 5; n++) begin
        e = (s == 3'd0) ? 16'h4004 : (s == 3'd1) ? 16'h1408 :
            (s == 3'd2) ? t2[k] : (s == 3'd3) ? t3[k] : 16'h0000;
        chk1("b2b", e, s);
        tick();
        if (s == 3'd4 || (s >= 3'd2 && e == 16'h0000)) break;
        s = s + 3'd1;
      end
      vectors++;
      if (step1 !== 3'd0) begin
        errors++;
        $display("FAIL b2b_restart op=%h: got step=%0d, expected 0", ops[k], step1);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_lda_full();
    test_alu();
    test_jumps();
    test_halt();
    test_pause();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
